// File: rtl/traffic_ctrl_array.sv
// traffic_ctrl_array: N-channel traffic-light controller with a global
// IDLE/RUN/PAUSE mode, per-channel programmable green/red durations and a
// fixed yellow phase, all advanced by a one-cycle timebase tick.
module traffic_ctrl_array #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned TIME_W    = 4,
    parameter int unsigned DEF_GREEN = 5,
    parameter int unsigned DEF_RED   = 5,
    parameter int unsigned YEL_TIME  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                go,
    input  logic                stop,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_ch,
    input  logic                cfg_color,
    input  logic [TIME_W-1:0]   cfg_time,
    input  logic                cfg_start,
    input  logic [SEL_W-1:0]    mon_ch,
    output logic [2*N_CH-1:0]   lights,
    output logic                running,
    output logic                paused,
    output logic [TIME_W-1:0]   mon_remain
);

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_PAUSE = 2'd2
    } mode_t;

    localparam logic [1:0]        LT_RED    = 2'b00;
    localparam logic [1:0]        LT_GREEN  = 2'b01;
    localparam logic [1:0]        LT_YEL    = 2'b10;
    localparam logic [TIME_W-1:0] RST_GREEN = TIME_W'(DEF_GREEN);
    localparam logic [TIME_W-1:0] RST_RED   = TIME_W'(DEF_RED);
    localparam logic [TIME_W-1:0] YEL_DUR   = TIME_W'(YEL_TIME);
    localparam bit                HAS_YEL   = (YEL_TIME != 0);

    mode_t             mode;
    mode_t             mode_next;

    logic              do_clear;
    logic              do_load;
    logic              do_step;
    logic              running_d;
    logic              paused_d;

    logic [TIME_W-1:0] green_dur [N_CH];
    logic [TIME_W-1:0] red_dur   [N_CH];
    logic [N_CH-1:0]   start_red;
    logic [TIME_W-1:0] remain    [N_CH];

    logic [1:0]        phase_d   [N_CH];
    logic [TIME_W-1:0] remain_d  [N_CH];
    logic [TIME_W-1:0] mon_d;
    logic [TIME_W-1:0] cfg_val;

    // Global mode register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= MODE_IDLE;
        end else begin
            mode <= mode_next;
        end
    end

    // Global next-mode: stop overrides go; go toggles RUN/PAUSE.
    always_comb begin
        mode_next = mode;
        if (stop) begin
            mode_next = MODE_IDLE;
        end else if (go) begin
            case (mode)
                MODE_IDLE:  mode_next = MODE_RUN;
                MODE_RUN:   mode_next = MODE_PAUSE;
                MODE_PAUSE: mode_next = MODE_RUN;
                default:    mode_next = MODE_IDLE;
            endcase
        end
    end

    // Mode-derived channel controls; a tick during any go/stop is dropped.
    always_comb begin
        do_clear  = stop;
        do_load   = (mode == MODE_IDLE) && go && !stop;
        do_step   = (mode == MODE_RUN) && tick && !go && !stop;
        running_d = (mode_next == MODE_RUN);
        paused_d  = (mode_next == MODE_PAUSE);
    end

    // Per-channel next phase/remain; loads read the stored (pre-write) config.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            phase_d[i]  = lights[2*i +: 2];
            remain_d[i] = remain[i];
            if (do_clear) begin
                phase_d[i]  = LT_RED;
                remain_d[i] = '0;
            end else if (do_load) begin
                if (start_red[i]) begin
                    phase_d[i]  = LT_RED;
                    remain_d[i] = red_dur[i];
                end else begin
                    phase_d[i]  = LT_GREEN;
                    remain_d[i] = green_dur[i];
                end
            end else if (do_step) begin
                if (remain[i] > TIME_W'(1)) begin
                    remain_d[i] = remain[i] - TIME_W'(1);
                end else begin
                    case (lights[2*i +: 2])
                        LT_GREEN: begin
                            if (HAS_YEL) begin
                                phase_d[i]  = LT_YEL;
                                remain_d[i] = YEL_DUR;
                            end else begin
                                phase_d[i]  = LT_RED;
                                remain_d[i] = red_dur[i];
                            end
                        end
                        LT_YEL: begin
                            phase_d[i]  = LT_RED;
                            remain_d[i] = red_dur[i];
                        end
                        default: begin
                            phase_d[i]  = LT_GREEN;
                            remain_d[i] = green_dur[i];
                        end
                    endcase
                end
            end
        end
    end

    // Monitor mux; unmatched selects (>= N_CH) read as zero.
    always_comb begin
        mon_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (mon_ch == SEL_W'(i)) begin
                mon_d = remain_d[i];
            end
        end
    end

    // A zero duration is stored as one tick.
    always_comb begin
        cfg_val = (cfg_time == '0) ? TIME_W'(1) : cfg_time;
    end

    // Channel configuration storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                green_dur[i] <= RST_GREEN;
                red_dur[i]   <= RST_RED;
            end
            start_red <= '0;
        end else if (cfg_we) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (cfg_ch == SEL_W'(i)) begin
                    if (cfg_color) begin
                        red_dur[i] <= cfg_val;
                    end else begin
                        green_dur[i] <= cfg_val;
                    end
                    start_red[i] <= cfg_start;
                end
            end
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            lights     <= '0;
            running    <= 1'b0;
            paused     <= 1'b0;
            mon_remain <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                remain[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                lights[2*i +: 2] <= phase_d[i];
                remain[i]        <= remain_d[i];
            end
            running    <= running_d;
            paused     <= paused_d;
            mon_remain <= mon_d;
        end
    end

endmodule
